score_packer: RTL and testbench
===============================

SCORE_PACKER -- requirements
Module: score_packer

Interface
REQ-001 SHALL have parameter NUM_SIZE, default 26: width of one unsigned class score.
REQ-002 SHALL have port Clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port GlobalResetN  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Clear  input  1  synchronous frame abort/restart.
REQ-005 SHALL have port ScoreIn  input  NUM_SIZE  incoming score, one class per beat, class 0 first.
REQ-006 SHALL have port ScoreValid  input  1  ScoreIn is valid this cycle.
REQ-007 SHALL have port ScoreReady  output  1  packer accepts a beat this cycle.
REQ-008 SHALL have port Num  output  NUM_SIZE*10  packed frame; class k at Num[NUM_SIZE*k +: NUM_SIZE].
REQ-009 SHALL have port NumValid  output  1  Num holds a complete 10-score frame.
REQ-010 SHALL have port NumAck  input  1  consumer has taken the frame.
REQ-011 SHALL have port Index  output  4  registered argmax of the frame (see Configuration).

Function
REQ-012 SHALL implement two states: FILL (ScoreReady=1, NumValid=0) and HOLD (ScoreReady=0, NumValid=1).
REQ-013 SHALL accept a beat only when ScoreValid=1 and ScoreReady=1 in the same cycle.
REQ-014 SHALL keep a 4-bit slot counter 0..9; an accepted beat writes slot[counter] and increments it.
REQ-015 SHALL on the accepted beat at counter=9 reset counter to 0 and enter HOLD; NumValid=1 in the following cycle (1-cycle latency from 10th beat).
REQ-016 SHALL hold Num, Index and NumValid stable in HOLD until NumAck=1 is sampled.
REQ-017 SHALL on NumAck=1 in HOLD return to FILL next cycle (NumValid=0, ScoreReady=1); a beat presented that cycle is not accepted.
REQ-018 SHALL ignore NumAck in FILL.
REQ-019 SHALL leave Num slot contents unchanged until overwritten by a new beat; slots not yet rewritten keep prior frame values.
REQ-020 SHALL on Clear=1 force FILL, counter=0, NumValid=0 next cycle, in any state, including mid-frame.
REQ-021 SHALL give Clear priority over a simultaneous accepted beat (beat discarded) and over NumAck.
REQ-022 SHALL not combinationally depend ScoreReady on ScoreValid.

Reset
REQ-023 SHALL on GlobalResetN=0 immediately set state=FILL, counter=0, Num=0, NumValid=0, Index=4'd15.
REQ-024 SHALL drive ScoreReady=0 while GlobalResetN=0 and ScoreReady=1 from the first edge after deassertion.
REQ-025 SHALL abandon any partial or held frame on reset without emitting NumValid.

Configuration
REQ-026 SHALL use macro SCORE_PACKER_ARGMAX_EN to compile in a running-argmax tracker.
REQ-027 SHALL with the macro defined track max unsigned: slot 0 loads max/index 0; slot 1 replaces if score >= max (tie selects 1); slots 2..9 replace only if score > max (earlier wins ties); Index valid whenever NumValid=1.
REQ-028 SHALL with the macro undefined tie Index to 4'd15 constantly and instantiate no comparator.
REQ-029 SHALL reset the tracker on Clear and at start of each frame.

Verification
REQ-030 SHALL cover: reset, then 10 beats 1..10 back-to-back -> NumValid=1 one cycle after beat 10, slot k=k+1, Index=9 (macro on), 15 (off).
REQ-031 SHALL cover: frame in HOLD, ScoreValid=1 held with 77 for 5 cycles, no NumAck -> ScoreReady=0, Num unchanged; NumAck -> next frame slot0=77 accepted only from the cycle after FILL resumes.
REQ-032 SHALL cover: all 10 scores equal 5 -> Index=1; scores {9,3,9,...,0} -> Index=0.
REQ-033 SHALL cover: Clear asserted on beat 6 with ScoreValid=1 -> counter=0, beat discarded, next 10 beats form a fresh frame.
REQ-034 SHALL cover: GlobalResetN pulled low mid-HOLD between edges -> NumValid=0, Num=0, Index=15 without waiting for Clk.
REQ-035 SHALL cover: ScoreValid toggling 1/0 every cycle -> frame completes after 20 cycles with correct slot order.

Source files
------------

// File: rtl/score_packer.sv
// Packs ten unsigned class scores, streamed one per beat, into a single frame and holds it until acknowledged.
// Define SCORE_PACKER_ARGMAX_EN to compile in a running argmax tracker driving Index.
module score_packer #(
  parameter int NUM_SIZE = 26
) (
  input  logic                  Clk,
  input  logic                  GlobalResetN,
  input  logic                  Clear,
  input  logic [NUM_SIZE-1:0]   ScoreIn,
  input  logic                  ScoreValid,
  output logic                  ScoreReady,
  output logic [NUM_SIZE*10-1:0] Num,
  output logic                  NumValid,
  input  logic                  NumAck,
  output logic [3:0]            Index
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   run_q;
  logic [NUM_SIZE*10-1:0] num_q;
  logic                   accept;

  // run_q keeps ScoreReady low until the first edge after reset release
  assign ScoreReady = run_q & (state_q == FILL);
  assign accept     = ScoreValid & ScoreReady;
  assign NumValid   = (state_q == HOLD);
  assign Num        = num_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (Clear) begin
      state_d = FILL;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            if (cnt_q == 4'd9) begin
              cnt_d   = 4'd0;
              state_d = HOLD;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        HOLD: begin
          if (NumAck) state_d = FILL;
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge GlobalResetN) begin
    if (!GlobalResetN) begin
      state_q <= FILL;
      cnt_q   <= 4'd0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
    end
  end

  // Slots not written in the current frame keep their previous contents
  always_ff @(posedge Clk or negedge GlobalResetN) begin
    if (!GlobalResetN) begin
      num_q <= '0;
    end else if (accept && !Clear) begin
      for (int k = 0; k < 10; k++) begin
        if (cnt_q == 4'(k)) num_q[NUM_SIZE*k +: NUM_SIZE] <= ScoreIn;
      end
    end
  end

`ifdef SCORE_PACKER_ARGMAX_EN
  logic [NUM_SIZE-1:0] max_q;
  logic [3:0]          idx_q;
  logic                take;

  // Slot 0 always loads; slot 1 wins ties; later slots need a strictly larger score
  always_comb begin
    take = 1'b0;
    if (cnt_q == 4'd0)      take = 1'b1;
    else if (cnt_q == 4'd1) take = (ScoreIn >= max_q);
    else                    take = (ScoreIn > max_q);
  end

  always_ff @(posedge Clk or negedge GlobalResetN) begin
    if (!GlobalResetN) begin
      max_q <= '0;
      idx_q <= 4'd15;
    end else if (Clear) begin
      max_q <= '0;
      idx_q <= 4'd15;
    end else if (accept && take) begin
      max_q <= ScoreIn;
      idx_q <= cnt_q;
    end
  end

  assign Index = idx_q;
`else
  assign Index = 4'd15;
`endif

endmodule

// File: tb/tb_score_packer.sv
// Directed bench for score_packer: a per-cycle vector table for the basic frame and hold behaviour,
// plus hand sequences for argmax ties, Clear mid-frame, throttled input and asynchronous reset.
module tb_score_packer;
  localparam int NS = 26;

`ifdef SCORE_PACKER_ARGMAX_EN
  localparam bit ARGMAX = 1'b1;
`else
  localparam bit ARGMAX = 1'b0;
`endif

  logic           Clk = 1'b0;
  logic           GlobalResetN;
  logic           Clear;
  logic [NS-1:0]  ScoreIn;
  logic           ScoreValid;
  logic           ScoreReady;
  logic [NS*10-1:0] Num;
  logic           NumValid;
  logic           NumAck;
  logic [3:0]     Index;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  score_packer #(.NUM_SIZE(NS)) dut (
    .Clk(Clk), .GlobalResetN(GlobalResetN), .Clear(Clear),
    .ScoreIn(ScoreIn), .ScoreValid(ScoreValid), .ScoreReady(ScoreReady),
    .Num(Num), .NumValid(NumValid), .NumAck(NumAck), .Index(Index)
  );

  typedef struct {
    logic          v;
    logic [NS-1:0] s;
    logic          ack;
    logic          rdy;
    logic          nv;
    logic [NS-1:0] s0;
    logic          fr;
    logic [3:0]    idx;
  } vec_t;

  vec_t          tbl [18];
  logic [NS-1:0] frame_s [10];

  function automatic logic [3:0] exp_idx(input logic [3:0] v);
    return ARGMAX ? v : 4'd15;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_frame(input string tag, input logic [3:0] idx);
    chk({tag, "_nv"}, 64'(NumValid), 64'd1);
    for (int k = 0; k < 10; k++)
      chk($sformatf("%s_slot%0d", tag, k), 64'(Num[NS*k +: NS]), 64'(frame_s[k]));
    chk({tag, "_idx"}, 64'(Index), 64'(exp_idx(idx)));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_nv"}, 64'(NumValid), 64'd0);
    chk({tag, "_idx"}, 64'(Index), 64'd15);
    chk({tag, "_rdy"}, 64'(ScoreReady), 64'd0);
    for (int k = 0; k < 10; k++)
      chk($sformatf("%s_slot%0d", tag, k), 64'(Num[NS*k +: NS]), 64'd0);
  endtask

  task automatic send_frame(input string tag, input logic [3:0] idx);
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      chk($sformatf("%s_rdy%0d", tag, k), 64'(ScoreReady), 64'd1);
      chk($sformatf("%s_nv%0d", tag, k), 64'(NumValid), 64'd0);
      ScoreValid = 1'b1;
      ScoreIn    = frame_s[k];
    end
    @(negedge Clk);
    ScoreValid = 1'b0;
    check_frame(tag, idx);
  endtask

  task automatic ack_frame(input string tag);
    @(negedge Clk);
    NumAck = 1'b1;
    @(negedge Clk);
    NumAck = 1'b0;
    chk({tag, "_ack_nv"}, 64'(NumValid), 64'd0);
    chk({tag, "_ack_rdy"}, 64'(ScoreReady), 64'd1);
  endtask

  initial begin
    // Frame 1..10, then 77 held during HOLD, ack, and 77 taken once FILL resumes
    for (int i = 0; i < 10; i++)
      tbl[i] = '{v:1'b1, s:NS'(i + 1), ack:1'b0, rdy:1'b1, nv:1'b0,
                 s0:(i == 0) ? NS'(0) : NS'(1), fr:1'b0, idx:4'd0};
    for (int i = 10; i < 15; i++)
      tbl[i] = '{v:1'b1, s:NS'(77), ack:1'b0, rdy:1'b0, nv:1'b1,
                 s0:NS'(1), fr:(i == 10), idx:4'd9};
    tbl[15] = '{v:1'b1, s:NS'(77), ack:1'b1, rdy:1'b0, nv:1'b1, s0:NS'(1), fr:1'b1, idx:4'd9};
    tbl[16] = '{v:1'b1, s:NS'(77), ack:1'b0, rdy:1'b1, nv:1'b0, s0:NS'(1), fr:1'b0, idx:4'd0};
    tbl[17] = '{v:1'b0, s:NS'(0),  ack:1'b0, rdy:1'b1, nv:1'b0, s0:NS'(77), fr:1'b0, idx:4'd0};

    GlobalResetN = 1'b0;
    Clear        = 1'b0;
    ScoreIn      = '0;
    ScoreValid   = 1'b0;
    NumAck       = 1'b0;
    #1;
    check_zero("reset");
    repeat (2) @(negedge Clk);
    GlobalResetN = 1'b1;

    for (int k = 0; k < 10; k++) frame_s[k] = NS'(k + 1);
    for (int i = 0; i < 18; i++) begin
      @(negedge Clk);
      chk($sformatf("tbl%0d_rdy", i), 64'(ScoreReady), 64'(tbl[i].rdy));
      chk($sformatf("tbl%0d_nv", i), 64'(NumValid), 64'(tbl[i].nv));
      chk($sformatf("tbl%0d_slot0", i), 64'(Num[NS-1:0]), 64'(tbl[i].s0));
      if (tbl[i].fr) check_frame($sformatf("tbl%0d", i), tbl[i].idx);
      ScoreValid = tbl[i].v;
      ScoreIn    = tbl[i].s;
      NumAck     = tbl[i].ack;
    end
    @(negedge Clk);
    chk("keep_slot0", 64'(Num[NS-1:0]), 64'd77);
    chk("keep_slot1", 64'(Num[2*NS-1:NS]), 64'd2);
    Clear = 1'b1;
    @(negedge Clk);
    Clear = 1'b0;
    chk("clear_rdy", 64'(ScoreReady), 64'd1);
    chk("clear_nv", 64'(NumValid), 64'd0);

    // Argmax ties
    for (int k = 0; k < 10; k++) frame_s[k] = NS'(5);
    send_frame("eq5", 4'd1);
    ack_frame("eq5");
    frame_s = '{NS'(9), NS'(3), NS'(9), NS'(2), NS'(9), NS'(1), NS'(0), NS'(4), NS'(5), NS'(0)};
    send_frame("first9", 4'd0);
    ack_frame("first9");

    // Clear on the sixth beat discards it and restarts the frame
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      ScoreValid = 1'b1;
      ScoreIn    = NS'(100 + k);
    end
    @(negedge Clk);
    ScoreIn = NS'(999);
    Clear   = 1'b1;
    @(negedge Clk);
    Clear      = 1'b0;
    ScoreValid = 1'b0;
    chk("midclr_rdy", 64'(ScoreReady), 64'd1);
    chk("midclr_nv", 64'(NumValid), 64'd0);
    for (int k = 0; k < 10; k++) frame_s[k] = NS'(200 + k);
    send_frame("fresh", 4'd9);
    ack_frame("fresh");

    // ScoreValid toggling every cycle
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      chk($sformatf("tog%0d_nv", c), 64'(NumValid), 64'(c == 19));
      ScoreValid = ((c % 2) == 0);
      ScoreIn    = NS'(300 + c / 2);
    end
    @(negedge Clk);
    ScoreValid = 1'b0;
    for (int k = 0; k < 10; k++) frame_s[k] = NS'(300 + k);
    check_frame("toggle", 4'd9);

    // Asynchronous reset while holding a frame
    @(posedge Clk);
    #2;
    GlobalResetN = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge Clk);
    GlobalResetN = 1'b1;
    #1;
    chk("rel_rdy_pre", 64'(ScoreReady), 64'd0);
    @(negedge Clk);
    chk("rel_rdy", 64'(ScoreReady), 64'd1);
    chk("rel_nv", 64'(NumValid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
